// File: rtl/dram_lsu.sv
// dram_lsu: load/store adapter placed directly in front of the single-port data
// RAM (word addressed, 32-bit data, 4 byte enables, 1-cycle read latency).
//
// It accepts one byte/half/word request at a time from the MEM stage and
// translates it into a RAM word address, byte enables and lane-replicated write
// data. Load data is lane-extracted and sign- or zero-extended. Misaligned,
// out-of-window and reserved-size accesses are answered with rsp_err=1 and never
// touch the RAM.
//
// Ports
//   clk, rst_n                   clock (rising edge), async active-low reset
//   req_valid/req_ready          request handshake
//   req_we, req_size,            store flag, size (0 byte, 1 half, 2 word, 3 rsvd),
//   req_unsigned                 load zero-extend
//   req_addr, req_wdata          byte address, right-justified store data
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata, rsp_err           extended load data (0 for stores/errors), error
//   ram_addr, ram_wr_data,       RAM word address, write data,
//   ram_wr_en, ram_wr_byte_en    write strobe and byte enables
//   ram_rd_data                  RAM read data (valid the cycle after the address)
module dram_lsu #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wr_data,
  output logic                  ram_wr_en,
  output logic [3:0]            ram_wr_byte_en,
  input  logic [31:0]           ram_rd_data
);

  // Lowest byte-address bit that lies above the RAM window.
  localparam int unsigned TAG_LSB = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] byte_enables(input logic [1:0] sz,
                                              input logic [1:0] o);
    logic [3:0] be;
    case (sz)
      2'd0:    be = 4'b0001 << o;
      2'd1:    be = 4'b0011 << o;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicating the store data across all lanes lets the byte enables alone
  // select the target lane, so no offset-dependent shifter is needed.
  function automatic logic [31:0] replicate_wdata(input logic [1:0]  sz,
                                                  input logic [31:0] wd);
    logic [31:0] r;
    case (sz)
      2'd0:    r = {4{wd[7:0]}};
      2'd1:    r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] rd,
                                              input logic [1:0]  o,
                                              input logic [1:0]  sz,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (o)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = o[1] ? rd[31:16] : rd[15:0];
    case (sz)
      2'd0:    r = {{24{~uns & b[7]}}, b};
      2'd1:    r = {{16{~uns & h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [1:0]            off;
  logic                  in_range;
  logic                  misaligned;
  logic                  err;
  logic                  fire;
  logic [ADDR_WIDTH-1:0] req_word;

  assign off        = req_addr[1:0];
  assign in_range   = (req_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign misaligned = ((req_size == 2'd1) && off[0]) ||
                      ((req_size == 2'd2) && (off != 2'd0));
  assign err        = !in_range || misaligned || (req_size == 2'd3);
  assign req_word   = req_addr[TAG_LSB-1:2];

  // Gating with rst_n keeps the request port closed while reset is asserted.
  assign req_ready  = (state_q == S_IDLE) && rst_n;
  assign fire       = req_valid && req_ready;

  // ---------------------------------------------------------------------------
  // RAM drive
  // ---------------------------------------------------------------------------
  // In IDLE the address follows the request so a load accepted this cycle has
  // its read data ready in RD; elsewhere it holds the accepted address.
  assign ram_addr       = ((state_q == S_IDLE) && rst_n) ? req_word : ram_addr_q;
  assign ram_wr_en      = fire && req_we && !err;
  assign ram_wr_byte_en = ram_wr_en ? byte_enables(req_size, off) : 4'b0000;
  assign ram_wr_data    = rst_n ? replicate_wdata(req_size, req_wdata) : 32'd0;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    ram_addr_d  = ram_addr_q;
    case (state_q)
      S_IDLE: begin
        ram_addr_d = req_word;
        if (fire) begin
          if (req_we || err) begin
            // Stores complete at the accept edge; errors never reach the RAM.
            state_d     = S_RESP;
            rsp_rdata_d = 32'd0;
            rsp_err_d   = err;
          end else begin
            state_d = S_RD;
            off_d   = off;
            size_d  = req_size;
            uns_d   = req_unsigned;
          end
        end
      end
      S_RD: begin
        rsp_rdata_d = load_extend(ram_rd_data, off_q, size_q, uns_q);
        rsp_err_d   = 1'b0;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      off_q       <= 2'd0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      ram_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      ram_addr_q  <= ram_addr_d;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dram_lsu.sv
module tb_dram_lsu;

  localparam logic [31:0] BASE = 32'h1000_0000;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [12:0] ram_addr;
  logic [31:0] ram_wr_data;
  logic        ram_wr_en;
  logic [3:0]  ram_wr_byte_en;
  logic [31:0] ram_rd_data = 32'd0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;
  int exp_wr  = 0;
  rsp_t exp_q[$];
  rsp_t mon_e;
  vec_t tv[$];
  logic [31:0] mem [0:8191];

  always #5 clk = ~clk;

  dram_lsu #(.ADDR_WIDTH(13), .BASE_ADDR(32'h1000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
    .ram_wr_byte_en(ram_wr_byte_en), .ram_rd_data(ram_rd_data)
  );

  // Behavioural single-port RAM: byte-enabled write, 1-cycle read latency.
  always @(posedge clk) begin
    if (ram_wr_en) begin
      n_wr++;
      for (int b = 0; b < 4; b++)
        if (ram_wr_byte_en[b]) mem[ram_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
    end
    ram_rd_data <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Response scoreboard: pop when a response is consumed at the next edge.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rdata 0x%08h err %0b, expected no response",
                 rsp_rdata, rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
      end
    end
  end

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] er, input logic ee,
                              input logic [3:0] be, input logic [31:0] ewd);
    vec_t v;
    v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee; v.exp_be = be; v.exp_wd = ewd;
    return v;
  endfunction

  // Call at posedge+1. Returns at posedge+1 just after the accept edge.
  task automatic issue(input vec_t v);
    int w;
    rsp_t r;
    w = 0;
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready 0 for addr 0x%08h, expected 1", v.addr);
      @(posedge clk); #1;
      req_valid = 1'b0;
      return;
    end
    chk("wr_en", {31'd0, ram_wr_en}, {31'd0, (v.exp_be != 4'd0)});
    chk("wr_byte_en", {28'd0, ram_wr_byte_en}, {28'd0, v.exp_be});
    if (v.exp_be != 4'd0) begin
      chk("wr_addr", {19'd0, ram_addr}, {19'd0, v.addr[14:2]});
      chk("wr_data", ram_wr_data, v.exp_wd);
      exp_wr++;
    end
    r.rdata = v.exp_rdata;
    r.err   = v.exp_err;
    exp_q.push_back(r);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    rsp_t r;
    int w;
    for (int i = 0; i < 8192; i++) mem[i] = 32'd0;

    // Vector table: we, size, uns, addr, wdata, exp_rdata, exp_err, exp_be, exp_wd
    tv.push_back(mk(1, 2, 0, BASE+32'h10, 32'hDEADBEEF, 32'h0, 0, 4'b1111, 32'hDEADBEEF));
    tv.push_back(mk(0, 0, 0, BASE+32'h13, 32'h0, 32'hFFFFFFDE, 0, 4'b0000, 32'h0));
    tv.push_back(mk(0, 0, 1, BASE+32'h13, 32'h0, 32'h000000DE, 0, 4'b0000, 32'h0));
    tv.push_back(mk(1, 1, 0, BASE+32'h12, 32'h00001234, 32'h0, 0, 4'b1100, 32'h12341234));
    tv.push_back(mk(0, 1, 0, BASE+32'h12, 32'h0, 32'h00001234, 0, 4'b0000, 32'h0));
    tv.push_back(mk(0, 2, 0, BASE+32'h10, 32'h0, 32'h1234BEEF, 0, 4'b0000, 32'h0));
    tv.push_back(mk(0, 1, 1, BASE+32'h10, 32'h0, 32'h0000BEEF, 0, 4'b0000, 32'h0));
    tv.push_back(mk(0, 1, 0, BASE+32'h10, 32'h0, 32'hFFFFBEEF, 0, 4'b0000, 32'h0));
    tv.push_back(mk(0, 0, 0, BASE+32'h10, 32'h0, 32'hFFFFFFEF, 0, 4'b0000, 32'h0));
    tv.push_back(mk(0, 0, 0, BASE+32'h11, 32'h0, 32'hFFFFFFBE, 0, 4'b0000, 32'h0));
    tv.push_back(mk(0, 0, 1, BASE+32'h12, 32'h0, 32'h00000034, 0, 4'b0000, 32'h0));
    tv.push_back(mk(1, 0, 0, BASE+32'h11, 32'h000000A5, 32'h0, 0, 4'b0010, 32'hA5A5A5A5));
    tv.push_back(mk(0, 2, 0, BASE+32'h10, 32'h0, 32'h1234A5EF, 0, 4'b0000, 32'h0));
    tv.push_back(mk(0, 0, 0, BASE+32'h11, 32'h0, 32'hFFFFFFA5, 0, 4'b0000, 32'h0));
    // Error cases: never write, respond with err and zero data.
    tv.push_back(mk(0, 2, 0, BASE+32'h2, 32'h0, 32'h0, 1, 4'b0000, 32'h0));
    tv.push_back(mk(1, 1, 0, BASE+32'h1, 32'h0000FFFF, 32'h0, 1, 4'b0000, 32'h0));
    tv.push_back(mk(0, 3, 0, BASE+32'h10, 32'h0, 32'h0, 1, 4'b0000, 32'h0));
    tv.push_back(mk(1, 3, 0, BASE+32'h14, 32'h55555555, 32'h0, 1, 4'b0000, 32'h0));
    tv.push_back(mk(1, 2, 0, BASE+32'h8000, 32'hBAD0BAD0, 32'h0, 1, 4'b0000, 32'h0));
    tv.push_back(mk(1, 2, 0, 32'h0FFFFFFC, 32'hBAD1BAD1, 32'h0, 1, 4'b0000, 32'h0));
    tv.push_back(mk(1, 1, 0, BASE+32'h3, 32'h0000BEEF, 32'h0, 1, 4'b0000, 32'h0));
    tv.push_back(mk(0, 1, 0, BASE+32'h11, 32'h0, 32'h0, 1, 4'b0000, 32'h0));
    // RAM contents unchanged by the errored accesses.
    tv.push_back(mk(0, 2, 0, BASE+32'h10, 32'h0, 32'h1234A5EF, 0, 4'b0000, 32'h0));
    tv.push_back(mk(0, 2, 0, BASE+32'h0, 32'h0, 32'h00000000, 0, 4'b0000, 32'h0));
    tv.push_back(mk(0, 2, 0, BASE+32'h14, 32'h0, 32'h00000000, 0, 4'b0000, 32'h0));
    // Top of the window is legal.
    tv.push_back(mk(1, 2, 0, BASE+32'h7FFC, 32'hCAFEF00D, 32'h0, 0, 4'b1111, 32'hCAFEF00D));
    tv.push_back(mk(0, 2, 0, BASE+32'h7FFC, 32'h0, 32'hCAFEF00D, 0, 4'b0000, 32'h0));
    tv.push_back(mk(0, 1, 1, BASE+32'h7FFE, 32'h0, 32'h0000CAFE, 0, 4'b0000, 32'h0));
    tv.push_back(mk(0, 0, 0, BASE+32'h7FFF, 32'h0, 32'hFFFFFFCA, 0, 4'b0000, 32'h0));

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_ram_wr_en", {31'd0, ram_wr_en}, 32'd0);
    chk("rst_ram_addr", {19'd0, ram_addr}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // Table-driven run, rsp_ready held high
    foreach (tv[i]) issue(tv[i]);

    // Latency: store responds at the accept edge, ready returns one cycle later
    issue(mk(1, 2, 0, BASE+32'h20, 32'h0BADF00D, 32'h0, 0, 4'b1111, 32'h0BADF00D));
    chk("st_rsp_valid_E", {31'd0, rsp_valid}, 32'd1);
    chk("st_req_ready_E", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("st_rsp_valid_E1", {31'd0, rsp_valid}, 32'd0);
    chk("st_req_ready_E1", {31'd0, req_ready}, 32'd1);
    // Load responds one edge later
    issue(mk(0, 2, 0, BASE+32'h20, 32'h0, 32'h0BADF00D, 0, 4'b0000, 32'h0));
    chk("ld_rsp_valid_E", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("ld_rsp_valid_E1", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
    chk("ld_req_ready_E2", {31'd0, req_ready}, 32'd1);

    // Backpressure with a queued request
    rsp_ready = 1'b0;
    issue(mk(0, 2, 0, BASE+32'h7FFC, 32'h0, 32'hCAFEF00D, 0, 4'b0000, 32'h0));
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b1;
    req_addr = BASE + 32'h13; req_wdata = 32'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_req_ready_release", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("bp_queued_accept", {31'd0, req_ready}, 32'd1);
    r.rdata = 32'h00000012;
    r.err   = 1'b0;
    exp_q.push_back(r);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset pulsed during RD
    issue(mk(0, 2, 0, BASE+32'h10, 32'h0, 32'h1234A5EF, 0, 4'b0000, 32'h0));
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("mid_rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("mid_rst_ram_wr_en", {31'd0, ram_wr_en}, 32'd0);
    chk("mid_rst_byte_en", {28'd0, ram_wr_byte_en}, 32'd0);
    chk("mid_rst_ram_addr", {19'd0, ram_addr}, 32'd0);
    chk("mid_rst_wr_data", ram_wr_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_req_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rel_no_stale_valid", {31'd0, rsp_valid}, 32'd0);
    end

    // Drain and final totals
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    chk("pending_responses", exp_q.size(), 32'd0);
    chk("ram_write_count", n_wr, exp_wr);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_lsu.md
Name: dram_lsu

Overview:
Load/store adapter that sits directly upstream of the single-port data RAM (dram: 13-bit word address, 32-bit data, 4 byte enables, 1-cycle read latency, no output register). It accepts byte, half and word load/store requests from the core's MEM stage over a valid/ready handshake and converts each one into RAM word address, byte enables and lane-shifted write data. Load data is lane-extracted and sign- or zero-extended, then returned on a valid/ready response channel. Misaligned and out-of-range accesses are flagged and never touch the RAM.

Parameters:
ADDR_WIDTH, 13, RAM word-address width; the byte window is 2^(ADDR_WIDTH+2) bytes.
BASE_ADDR, 32'h1000_0000, byte base of the RAM window; must be aligned to 2^(ADDR_WIDTH+2).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_we  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as error)
req_unsigned  in  1  load zero-extend (LBU/LHU); ignored for stores
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned, out-of-range or size==3
ram_addr  out  ADDR_WIDTH  to dram addr
ram_wr_data  out  32  to dram wr_data
ram_wr_en  out  1  to dram wr_en
ram_wr_byte_en  out  4  to dram wr_byte_en
ram_rd_data  in  32  from dram rd_data

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; req_ready=0 while reset is asserted and 1 in the first cycle after release; rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_wr_en=0, ram_wr_byte_en=0, ram_addr=0, ram_wr_data=0. Reset mid-operation drops any in-flight request and response; no RAM write is issued.
- Decode is combinational on req_*:
  - off = req_addr[1:0].
  - in_range = (req_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]).
  - misaligned = (size==1 && off[0]) || (size==2 && off!=0).
  - err = !in_range || misaligned || size==3.
- RAM drive:
  - ram_addr = req_addr[ADDR_WIDTH+1:2] whenever state==IDLE; ram_addr holds its last value otherwise.
  - ram_wr_en = fire && req_we && !err, where fire = req_valid && req_ready.
  - ram_wr_byte_en: byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111. It is 0 unless ram_wr_en is 1.
  - ram_wr_data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- States:
  - IDLE: req_ready=1.
    - Store or error fire -> RESP; the response is registered at that edge (rsp_rdata=0, rsp_err=err).
    - Non-error load fire -> RD; latch off, size and unsigned.
  - RD: req_ready=0. ram_rd_data is valid this cycle. Extract the lane, extend, and register into rsp_rdata with rsp_err=0 -> RESP.
    - Byte: lane = rd_data[8*off+7 -: 8].
    - Half: lane = rd_data[16*off[1]+15 -: 16].
    - Extend with 0 if unsigned, else with the lane MSB.
  - RESP: rsp_valid=1, req_ready=0.
    - rsp_ready=1 -> IDLE; rsp_valid drops the next cycle.
    - rsp_ready=0 -> hold; rsp_rdata and rsp_err stay stable.
- Latency, counted as the edge at which rsp_valid rises after the accept edge E: store/error at E; load at E+1 (valid from the cycle after RD).
- Throughput: at most one request is outstanding. A new request is accepted only in IDLE, so with rsp_ready=1 the minimum is 2 cycles per store and 3 per load.
- A store followed by a load to the same address returns the new data; the write has completed before the load is accepted.
- Top-of-window address BASE_ADDR+2^(ADDR_WIDTH+2)-4 is legal. BASE_ADDR+2^(ADDR_WIDTH+2) is out of range; ram_addr must not wrap to 0 with a write.

Test Plan:
- Reset, then SW 0xDEADBEEF @BASE+0x10, rsp_ready=1 -> one cycle with ram_wr_en=1, ram_addr=4, byte_en=1111; rsp_valid with rsp_err=0 and rsp_rdata=0; req_ready=1 again 2 cycles after accept.
- LB @BASE+0x13, then LBU @BASE+0x13, after the SW above -> rsp_rdata 0xFFFFFFDE, then 0x000000DE; rsp_valid asserts 2 cycles after each accept.
- SH 0x1234 @BASE+0x12, then LH @BASE+0x12 -> byte_en=1100, wr_data=0x12341234; load returns 0x00001234. LW @BASE+0x10 returns 0x1234BEEF.
- Misaligned LW @BASE+0x2, SH @BASE+0x1, size=3, and SW @BASE+0x8000 -> rsp_err=1, rsp_rdata=0, ram_wr_en never asserts, RAM contents unchanged (read back).
- Backpressure: load with rsp_ready=0 for 5 cycles -> rsp_valid and data stay stable and req_ready=0 throughout; a queued request is accepted in the cycle after rsp_ready=1.
- rst_n pulsed low during RD -> all outputs zero immediately; after release req_ready=1 and no stale rsp_valid appears.
